// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns byte address, funct3 and store data into
// word-addressed, byte-masked memory accesses, splitting word-crossing accesses in two.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              illegal_o,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [3:0]        hi_mask_q;
    logic [31:0]       hi_data_q;
    logic [ADDR_W-1:0] hi_addr_q;
    logic              load_q;
    logic [31:0]       lo_q;

    logic [7:0]        size_mask;
    logic [7:0]        lane_mask;
    logic [63:0]       shifted;
    logic [ADDR_W-1:0] base_word;
    logic              bad_req;
    logic              legal_req;
    logic              reject_req;
    logic              split_req;

    logic [63:0]       ext_src;
    logic [1:0]        ext_off;
    logic [2:0]        ext_f3;
    logic [31:0]       ext_word;
    logic [31:0]       ext_data;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^addr_i[31:ADDR_W+2];

    always_comb begin
        size_mask = 8'h0F;
        case (funct3_i[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            default: size_mask = 8'h0F;
        endcase
    end

    assign lane_mask = size_mask << addr_i[1:0];
    assign shifted   = {32'b0, wdata_i} << {addr_i[1:0], 3'b000};
    assign base_word = addr_i[ADDR_W+1:2];
    assign split_req = |lane_mask[7:4];

    // Reserved funct3 codes, ambiguous load/store flags, and unsigned stores are rejected.
    assign bad_req    = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) ||
                        (load_i == store_i) || (store_i && funct3_i[2]);
    assign legal_req  = valid_i && (state_q == IDLE) && !bad_req;
    assign reject_req = valid_i && (state_q == IDLE) && bad_req;

    // Loads are extracted from {hi, lo}: hi is the live memory word during SPLIT, zero otherwise.
    always_comb begin
        ext_src = {32'b0, mem_data_out};
        ext_off = addr_i[1:0];
        ext_f3  = funct3_i;
        if (state_q == SPLIT) begin
            ext_src = {mem_data_out, lo_q};
            ext_off = off_q;
            ext_f3  = f3_q;
        end
        ext_word = 32'(ext_src >> {ext_off, 3'b000});
        case (ext_f3)
            3'b000:  ext_data = {{24{ext_word[7]}}, ext_word[7:0]};
            3'b001:  ext_data = {{16{ext_word[15]}}, ext_word[15:0]};
            3'b100:  ext_data = {24'b0, ext_word[7:0]};
            3'b101:  ext_data = {16'b0, ext_word[15:0]};
            default: ext_data = ext_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        mem_request = 1'b0;
        mem_we_re   = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        mem_mask    = '0;
        case (state_q)
            IDLE: begin
                if (legal_req) begin
                    mem_request = 1'b1;
                    mem_we_re   = store_i;
                    mem_address = base_word;
                    mem_mask    = load_i ? 4'hF : lane_mask[3:0];
                    mem_data_in = shifted[31:0];
                    if (split_req) begin
                        busy_o  = 1'b1;
                        state_d = SPLIT;
                    end
                end
            end
            SPLIT: begin
                busy_o      = 1'b1;
                mem_request = 1'b1;
                mem_we_re   = ~load_q;
                mem_address = hi_addr_q;
                mem_mask    = hi_mask_q;
                mem_data_in = hi_data_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also abandons any pending second half of a split access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            f3_q          <= '0;
            off_q         <= '0;
            hi_mask_q     <= '0;
            hi_data_q     <= '0;
            hi_addr_q     <= '0;
            load_q        <= 1'b0;
            lo_q          <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            illegal_o     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdata_valid_o <= 1'b0;
            illegal_o     <= reject_req;
            if (legal_req && split_req) begin
                f3_q      <= funct3_i;
                off_q     <= addr_i[1:0];
                hi_mask_q <= lane_mask[7:4];
                hi_data_q <= shifted[63:32];
                hi_addr_q <= base_word + 1'b1;
                load_q    <= load_i;
                lo_q      <= mem_data_out;
            end
            if ((legal_req && !split_req && load_i) || (state_q == SPLIT && load_q)) begin
                rdata_o       <= ext_data;
                rdata_valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, corner sequences,
// and randomized accesses against a byte-addressed reference memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        load_i;
    logic        store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        illegal_o;
    logic        mem_request;
    logic        mem_we_re;
    logic [7:0]  mem_address;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_mask;
    logic [31:0] mem_data_out;

    int n_compared = 0;
    int n_mismatched = 0;
    string tag = "";

    logic [31:0] dmem [256];
    logic [7:0]  ref_mem [1024];

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ill;
        logic        spl;
        logic [7:0]  a0;
        logic [3:0]  m0;
        logic [31:0] d0;
        logic [7:0]  a1;
        logic [3:0]  m1;
        logic [31:0] d1;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    load_store_unit #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .load_i(load_i), .store_i(store_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .illegal_o(illegal_o),
        .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_mask(mem_mask), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Byte-masked data memory with a combinational read port.
    assign mem_data_out = dmem[mem_address];
    always @(posedge clk) begin
        if (mem_request && mem_we_re)
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) dmem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s%s: got %h, expected %h", tag, name, actual, expected);
        end
    endtask

    function automatic int accessSize(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] raw = 32'b0;
        int n = accessSize(f3);
        for (int i = 0; i < n; i++) raw[8*i +: 8] = ref_mem[(int'(addr[9:0]) + i) % 1024];
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    task automatic modelStore(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
        int n = accessSize(f3);
        for (int i = 0; i < n; i++) ref_mem[(int'(addr[9:0]) + i) % 1024] = data[8*i +: 8];
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        valid_i = 1'b1; load_i = ld; store_i = st; funct3_i = f3; addr_i = addr; wdata_i = wdata;
        #1;
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(v.ld, v.st, v.f3, v.addr, v.wdata);
        if (v.ill) begin
            checkOutput("ill_request", mem_request, 0);
            checkOutput("ill_busy", busy_o, 0);
            @(posedge clk); #1; valid_i = 1'b0;
            checkOutput("ill_pulse", illegal_o, 1);
            checkOutput("ill_rdata", rdata_o, v.rd);
            checkOutput("ill_rvalid", rdata_valid_o, 0);
            @(posedge clk); #1;
            checkOutput("ill_pulse_end", illegal_o, 0);
        end else begin
            modelStoreIf(v);
            checkOutput("request", mem_request, 1);
            checkOutput("we", mem_we_re, v.st);
            checkOutput("addr0", mem_address, v.a0);
            checkOutput("mask0", mem_mask, v.m0);
            if (v.st) checkOutput("data0", mem_data_in, v.d0);
            checkOutput("busy0", busy_o, v.spl);
            @(posedge clk); #1; valid_i = 1'b0;
            if (v.spl) begin
                checkOutput("busy1", busy_o, 1);
                checkOutput("request1", mem_request, 1);
                checkOutput("we1", mem_we_re, v.st);
                checkOutput("addr1", mem_address, v.a1);
                if (v.st) begin
                    checkOutput("mask1", mem_mask, v.m1);
                    checkOutput("data1", mem_data_in, v.d1);
                end
                checkOutput("rvalid_early", rdata_valid_o, 0);
                @(posedge clk); #1;
            end
            checkOutput("busy_done", busy_o, 0);
            checkOutput("rvalid", rdata_valid_o, v.ld);
            if (v.ld) checkOutput("rdata", rdata_o, v.rd);
            @(posedge clk); #1;
            checkOutput("rvalid_pulse_end", rdata_valid_o, 0);
        end
    endtask

    task automatic modelStoreIf(input vec_t v);
        if (v.st) modelStore(v.addr, v.f3, v.wdata);
    endtask

    task automatic randomAccess(input int idx);
        logic ld = 1'($urandom_range(0, 1));
        logic [2:0] f3;
        logic [31:0] addr = $urandom;
        logic [31:0] wdata = $urandom;
        logic exp_split;
        logic [31:0] exp_rd;
        logic [31:0] got_rd = 32'b0;
        int seen = 0;
        int k_sel = $urandom_range(0, ld ? 4 : 2);
        f3 = (k_sel == 3) ? 3'b100 : (k_sel == 4) ? 3'b101 : 3'(k_sel);
        exp_split = (int'(addr[1:0]) + accessSize(f3)) > 4;
        exp_rd = modelLoad(addr, f3);
        if (!ld) modelStore(addr, f3, wdata);
        tag = $sformatf("rnd%0d_", idx);
        applyStimulus(ld, !ld, f3, addr, wdata);
        checkOutput("busy", busy_o, exp_split);
        checkOutput("addr0", mem_address, addr[9:2]);
        @(posedge clk); #1; valid_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (rdata_valid_o && seen == 0) begin
                seen = k;
                got_rd = rdata_o;
            end
        end
        checkOutput("latency", seen, ld ? (exp_split ? 2 : 1) : 0);
        if (ld) checkOutput("rdata", got_rd, exp_rd);
        checkOutput("busy_end", busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 32'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'b0;
        rst = 1'b1; valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
        funct3_i = 3'b0; addr_i = 32'b0; wdata_i = 32'b0;

        //            ld   st   f3      addr          wdata         ill  spl  a0     m0    d0            a1     m1    d1            rd
        vecs.push_back('{1'b0,1'b1,3'b010,32'h00000010,32'hDEADBEEF,1'b0,1'b0,8'h04,4'hF,32'hDEADBEEF,8'h00,4'h0,32'h00000000,32'h00000000});
        vecs.push_back('{1'b1,1'b0,3'b010,32'h00000010,32'h00000000,1'b0,1'b0,8'h04,4'hF,32'h00000000,8'h00,4'h0,32'h00000000,32'hDEADBEEF});
        vecs.push_back('{1'b0,1'b1,3'b000,32'h00000013,32'h00000080,1'b0,1'b0,8'h04,4'h8,32'h80000000,8'h00,4'h0,32'h00000000,32'h00000000});
        vecs.push_back('{1'b1,1'b0,3'b000,32'h00000013,32'h00000000,1'b0,1'b0,8'h04,4'hF,32'h00000000,8'h00,4'h0,32'h00000000,32'hFFFFFF80});
        vecs.push_back('{1'b1,1'b0,3'b100,32'h00000013,32'h00000000,1'b0,1'b0,8'h04,4'hF,32'h00000000,8'h00,4'h0,32'h00000000,32'h00000080});
        vecs.push_back('{1'b0,1'b1,3'b010,32'h0000000E,32'h11223344,1'b0,1'b1,8'h03,4'hC,32'h33440000,8'h04,4'h3,32'h00001122,32'h00000000});
        vecs.push_back('{1'b1,1'b0,3'b010,32'h0000000E,32'h00000000,1'b0,1'b1,8'h03,4'hF,32'h00000000,8'h04,4'h0,32'h00000000,32'h11223344});
        vecs.push_back('{1'b0,1'b1,3'b001,32'h000003FF,32'h0000FFAB,1'b0,1'b1,8'hFF,4'h8,32'hAB000000,8'h00,4'h1,32'h000000FF,32'h00000000});
        vecs.push_back('{1'b1,1'b0,3'b001,32'h000003FF,32'h00000000,1'b0,1'b1,8'hFF,4'hF,32'h00000000,8'h00,4'h0,32'h00000000,32'hFFFFFFAB});
        vecs.push_back('{1'b1,1'b0,3'b101,32'h000003FF,32'h00000000,1'b0,1'b1,8'hFF,4'hF,32'h00000000,8'h00,4'h0,32'h00000000,32'h0000FFAB});
        vecs.push_back('{1'b0,1'b1,3'b001,32'h00000005,32'h00001234,1'b0,1'b0,8'h01,4'h6,32'h00123400,8'h00,4'h0,32'h00000000,32'h00000000});
        vecs.push_back('{1'b1,1'b0,3'b001,32'h00000005,32'h00000000,1'b0,1'b0,8'h01,4'hF,32'h00000000,8'h00,4'h0,32'h00000000,32'h00001234});
        vecs.push_back('{1'b1,1'b0,3'b100,32'h00000006,32'h00000000,1'b0,1'b0,8'h01,4'hF,32'h00000000,8'h00,4'h0,32'h00000000,32'h00000012});
        vecs.push_back('{1'b1,1'b0,3'b010,32'h00000011,32'h00000000,1'b0,1'b1,8'h04,4'hF,32'h00000000,8'h05,4'h0,32'h00000000,32'h0080AD11});
        vecs.push_back('{1'b1,1'b0,3'b011,32'h00000010,32'h00000000,1'b1,1'b0,8'h00,4'h0,32'h00000000,8'h00,4'h0,32'h00000000,32'h0080AD11});
        vecs.push_back('{1'b1,1'b1,3'b010,32'h00000010,32'h55555555,1'b1,1'b0,8'h00,4'h0,32'h00000000,8'h00,4'h0,32'h00000000,32'h0080AD11});
        vecs.push_back('{1'b0,1'b0,3'b010,32'h00000010,32'h55555555,1'b1,1'b0,8'h00,4'h0,32'h00000000,8'h00,4'h0,32'h00000000,32'h0080AD11});
        vecs.push_back('{1'b0,1'b1,3'b100,32'h00000010,32'h55555555,1'b1,1'b0,8'h00,4'h0,32'h00000000,8'h00,4'h0,32'h00000000,32'h0080AD11});
        vecs.push_back('{1'b1,1'b0,3'b110,32'h00000010,32'h00000000,1'b1,1'b0,8'h00,4'h0,32'h00000000,8'h00,4'h0,32'h00000000,32'h0080AD11});

        // Reset values, sampled while reset is held.
        #7;
        tag = "reset_";
        checkOutput("busy", busy_o, 0);
        checkOutput("rdata", rdata_o, 0);
        checkOutput("rvalid", rdata_valid_o, 0);
        checkOutput("illegal", illegal_o, 0);
        checkOutput("request", mem_request, 0);
        checkOutput("addr", mem_address, 0);
        checkOutput("mask", mem_mask, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("vec%0d_", i);
            runVector(vecs[i]);
        end

        // Back-to-back aligned loads at one per cycle.
        tag = "b2b_";
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0);
        checkOutput("busy0", busy_o, 0);
        @(posedge clk); #1;
        addr_i = 32'h0000000C;
        checkOutput("rvalid0", rdata_valid_o, 1);
        checkOutput("rdata0", rdata_o, 32'h80AD1122);
        checkOutput("busy1", busy_o, 0);
        checkOutput("request1", mem_request, 1);
        @(posedge clk); #1; valid_i = 1'b0;
        checkOutput("rvalid1", rdata_valid_o, 1);
        checkOutput("rdata1", rdata_o, 32'h33440000);
        @(posedge clk); #1;
        checkOutput("rvalid_end", rdata_valid_o, 0);

        // Reset asserted during the second half of a split store.
        tag = "rstsplit_";
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000001E, 32'hCAFEF00D);
        @(posedge clk); #1; valid_i = 1'b0;
        checkOutput("busy_split", busy_o, 1);
        rst = 1'b1;
        #1;
        checkOutput("busy", busy_o, 0);
        checkOutput("request", mem_request, 0);
        checkOutput("we", mem_we_re, 0);
        checkOutput("addr", mem_address, 0);
        checkOutput("mask", mem_mask, 0);
        checkOutput("data", mem_data_in, 0);
        checkOutput("rdata", rdata_o, 0);
        checkOutput("rvalid", rdata_valid_o, 0);
        @(posedge clk); #1;
        checkOutput("rvalid_after", rdata_valid_o, 0);
        @(negedge clk); rst = 1'b0;
        ref_mem[10'h01E] = 8'h0D;
        ref_mem[10'h01F] = 8'hF0;
        checkOutput("word8", dmem[8], 32'h00000000);
        checkOutput("word7", dmem[7], 32'hF00D0000);
        tag = "rstsplit_lw7_";
        runVector('{1'b1,1'b0,3'b010,32'h0000001C,32'h0,1'b0,1'b0,8'h07,4'hF,32'h0,8'h00,4'h0,32'h0,32'hF00D0000});

        for (int i = 0; i < 300; i++) randomAccess(i);

        tag = "final_";
        for (int w = 0; w < 256; w++)
            checkOutput($sformatf("word%0d", w), dmem[w],
                        {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
